servo_axis_driver: RTL and testbench
====================================

Name: servo_axis_driver

Overview:
- Consumes one axis of the joystick decoder's 2-bit direction code (01 = decrease, 10 = increase, 00 = hold) and integrates it into a saturating servo position.
- Generates the standard hobby-servo PWM from that position.
- Instantiated once per axis (x pan, y tilt) between the joystick decoder and the servo header pins.
- Position changes only at PWM frame boundaries, so every pulse is glitch-free.

Parameters:
- PWM_PERIOD_CYC, 2_000_000: clocks per PWM frame (20 ms at 100 MHz).
- MIN_PULSE_CYC, 100_000: minimum high time in clocks (1.0 ms).
- MAX_PULSE_CYC, 200_000: maximum high time in clocks (2.0 ms).
- CENTER_PULSE_CYC, 150_000: position after reset (1.5 ms).
- STEP_CYC, 1_000: base position change per update.
- FRAMES_PER_UPDATE, 2: PWM frames between position updates (≥1).

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- direction  input  2  from decoder: 01 dec, 10 inc, 00/11 hold.
- enable  input  1  0 = freeze position; PWM keeps running.
- pwm_out  output  1  servo control pulse.
- position  output  PW  current pulse width in clocks; PW = $clog2(PWM_PERIOD_CYC+1).
- frame_tick  output  1  one-cycle pulse on the first cycle of each frame.
- at_min  output  1  position == MIN_PULSE_CYC.
- at_max  output  1  position == MAX_PULSE_CYC.

Behaviour:
- Reset: synchronous on rising CLK while RST = 1.
  - frame counter 0, update counter 0, position = CENTER_PULSE_CYC.
  - pwm_out 0, frame_tick 0, at_min 0, at_max 0.
  - Reset mid-frame truncates the pulse immediately.
- Frame counter: 0..PWM_PERIOD_CYC-1, wraps to 0. frame_tick = 1 for the cycle after count reaches 0, i.e. registered, 1-cycle latency.
- Latched width: pulse_q loads position when the frame counter equals 0.
  - pwm_out is registered: pwm_out = (frame_cnt < pulse_q).
  - High time is exactly pulse_q clocks per frame, delayed one cycle from the counter.
- Update counter: counts frame wraps 0..FRAMES_PER_UPDATE-1. An update fires on the wrap cycle when the update counter is at FRAMES_PER_UPDATE-1.
- Update rule, evaluated on the update cycle only, using direction sampled that cycle:
  - enable = 0, or direction 00/11: hold.
  - 10: position = min(position + step, MAX_PULSE_CYC).
  - 01: position = max(position − step, MIN_PULSE_CYC), with no unsigned underflow; compare before subtracting.
  - Arithmetic is PW+1 bits wide to avoid overflow.
- Direction changes between update cycles are ignored (decoder output is combinational and may glitch).
- at_min/at_max are registered from the new position; they are valid the cycle after the position updates.
- Saturation: further steps toward the limit hold the position and keep the flag asserted.
- Stepping back off a limit deasserts the flag at the next update.

Optional Feature:
- Macro: SERVO_RAMP_EN.
- Defined:
  - A run counter (0..15) increments on each update with the same non-hold direction as the previous update.
  - It resets to 0 on hold, direction reversal, or enable = 0.
  - step = STEP_CYC for run 0–3, 2×STEP_CYC for run 4–7, 4×STEP_CYC for run ≥8. The counter saturates at 15.
- Undefined: step = STEP_CYC always; no run counter logic is synthesized.

Decomposition:
- Package servo_pkg: direction encodings DIR_HOLD = 2'b00, DIR_DEC = 2'b01, DIR_INC = 2'b10; ramp thresholds 4 and 8; ramp multipliers.
- Sub-module pwm_frame_timer: owns the frame counter and frame_tick, parameterized by PWM_PERIOD_CYC.
- servo_axis_driver instantiates the timer and holds the update, position and PWM logic.

Test Plan (sim params: PWM_PERIOD_CYC = 100, MIN = 10, MAX = 50, CENTER = 30, STEP = 5, FRAMES_PER_UPDATE = 1):
1. Reset, then direction = 00 for 5 frames → position 30 every frame, pwm_out high exactly 30 cycles per frame, frame_tick every 100 cycles.
2. direction = 10 held → position 35, 40, 45, 50, 50 on successive frames; at_max asserts after position reaches 50; pulse width is never >50.
3. direction = 01 held from 30 → 25, 20, 15, 10, 10; at_min = 1, no wrap below 10. Then direction = 10 → 15 and at_min = 0.
4. Toggle direction 10↔01 every 7 cycles mid-frame, with 00 on the update cycle → position unchanged. Set enable = 0 with direction = 10 → position frozen, PWM still 30 high.
5. Assert RST at frame_cnt = 20 while position = 45 → pwm_out 0 the next cycle, position 30, next frame 30 high.
6. With SERVO_RAMP_EN defined, direction = 10 held from 10 (MAX raised to 99) → steps 5, 5, 5, 5, 10, 10, 10, 10, 20…; a single 00 update restarts the steps at 5.

Source files
------------

// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared constants for the servo axis driver:
//   - direction encodings produced by the joystick decoder
//   - step-ramp thresholds and multipliers (used only when SERVO_RAMP_EN is
//     defined at build time)
// -----------------------------------------------------------------------------
package servo_pkg;

  // Direction codes from the joystick decoder. 2'b11 is not produced by a
  // healthy decoder and is treated as hold.
  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_DEC  = 2'b01;
  localparam logic [1:0] DIR_INC  = 2'b10;

  // Step ramp: the run counter tracks consecutive same-direction updates.
  localparam int         RUN_W          = 4;
  localparam logic [3:0] RUN_MAX        = 4'd15;
  localparam logic [3:0] RAMP_MID_RUN   = 4'd4;  // run >= 4 -> 2x step
  localparam logic [3:0] RAMP_HIGH_RUN  = 4'd8;  // run >= 8 -> 4x step
  localparam int         RAMP_MID_MULT  = 2;
  localparam int         RAMP_HIGH_MULT = 4;

endpackage

// File: rtl/pwm_frame_timer.sv
// -----------------------------------------------------------------------------
// pwm_frame_timer
// Free-running PWM frame counter, 0 .. PWM_PERIOD_CYC-1, wrapping to 0.
//
// Ports:
//   CLK          system clock
//   RST          synchronous, active-high reset
//   frame_cnt    current position inside the frame
//   frame_start  combinational: frame_cnt == 0
//   frame_wrap   combinational: frame_cnt == PWM_PERIOD_CYC-1 (last cycle)
//   frame_tick   registered one-cycle pulse, the cycle after frame_cnt == 0
// -----------------------------------------------------------------------------
module pwm_frame_timer #(
  parameter int PWM_PERIOD_CYC = 2_000_000,
  parameter int CW             = $clog2(PWM_PERIOD_CYC + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  output logic [CW-1:0] frame_cnt,
  output logic          frame_start,
  output logic          frame_wrap,
  output logic          frame_tick
);

  localparam logic [CW-1:0] LAST_CNT = CW'(PWM_PERIOD_CYC - 1);

  assign frame_start = (frame_cnt == '0);
  assign frame_wrap  = (frame_cnt == LAST_CNT);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_cnt  <= frame_wrap ? '0 : frame_cnt + CW'(1);
      frame_tick <= frame_start;
    end
  end

endmodule

// File: rtl/servo_axis_driver.sv
// -----------------------------------------------------------------------------
// servo_axis_driver
// Integrates one axis of the joystick decoder's direction code into a
// saturating servo position and drives a hobby-servo PWM from it. The position
// only changes on the last cycle of a frame, and the pulse width is latched at
// the start of each frame, so every pulse is whole and glitch-free.
//
// Build option:
//   SERVO_RAMP_EN  when defined, consecutive same-direction updates grow the
//                  step (1x for run 0-3, 2x for run 4-7, 4x for run >= 8).
//
// Ports:
//   CLK         system clock
//   RST         synchronous, active-high reset
//   direction   decoder code: 01 dec, 10 inc, 00/11 hold
//   enable      0 freezes the position; PWM keeps running
//   pwm_out     servo control pulse (registered)
//   position    current pulse width in clocks
//   frame_tick  one-cycle pulse on the first cycle of each frame
//   at_min      position == MIN_PULSE_CYC (registered, one cycle behind)
//   at_max      position == MAX_PULSE_CYC (registered, one cycle behind)
// -----------------------------------------------------------------------------
module servo_axis_driver
  import servo_pkg::*;
#(
  parameter  int PWM_PERIOD_CYC    = 2_000_000,
  parameter  int MIN_PULSE_CYC     = 100_000,
  parameter  int MAX_PULSE_CYC     = 200_000,
  parameter  int CENTER_PULSE_CYC  = 150_000,
  parameter  int STEP_CYC          = 1_000,
  parameter  int FRAMES_PER_UPDATE = 2,
  localparam int PW                = $clog2(PWM_PERIOD_CYC + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    direction,
  input  logic          enable,
  output logic          pwm_out,
  output logic [PW-1:0] position,
  output logic          frame_tick,
  output logic          at_min,
  output logic          at_max
);

  // One extra bit so position + step can never wrap before saturation.
  localparam int AW = PW + 1;

  localparam logic [PW-1:0] MIN_POS    = PW'(MIN_PULSE_CYC);
  localparam logic [PW-1:0] MAX_POS    = PW'(MAX_PULSE_CYC);
  localparam logic [PW-1:0] CENTER_POS = PW'(CENTER_PULSE_CYC);
  localparam logic [AW-1:0] MIN_EXT    = AW'(MIN_PULSE_CYC);
  localparam logic [AW-1:0] MAX_EXT    = AW'(MAX_PULSE_CYC);
  localparam logic [AW-1:0] STEP_X1    = AW'(STEP_CYC);

  localparam int            UW       = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;
  localparam logic [UW-1:0] UPD_LAST = UW'(FRAMES_PER_UPDATE - 1);

  // ---------------------------------------------------------------------------
  // Frame timing
  // ---------------------------------------------------------------------------
  logic [PW-1:0] frame_cnt;
  logic          frame_start;
  logic          frame_wrap;

  pwm_frame_timer #(
    .PWM_PERIOD_CYC (PWM_PERIOD_CYC),
    .CW             (PW)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .frame_cnt   (frame_cnt),
    .frame_start (frame_start),
    .frame_wrap  (frame_wrap),
    .frame_tick  (frame_tick)
  );

  // ---------------------------------------------------------------------------
  // Update scheduling: one update every FRAMES_PER_UPDATE frame wraps.
  // ---------------------------------------------------------------------------
  logic [UW-1:0] upd_cnt;
  logic          update_now;

  assign update_now = frame_wrap && (upd_cnt == UPD_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      upd_cnt <= '0;
    end else if (frame_wrap) begin
      upd_cnt <= (upd_cnt == UPD_LAST) ? '0 : upd_cnt + UW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Step size
  // ---------------------------------------------------------------------------
  logic [AW-1:0] step_ext;

`ifdef SERVO_RAMP_EN
  localparam logic [AW-1:0] STEP_X2 = AW'(STEP_CYC * RAMP_MID_MULT);
  localparam logic [AW-1:0] STEP_X4 = AW'(STEP_CYC * RAMP_HIGH_MULT);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_next;
  logic [1:0]       last_dir_q;
  logic [1:0]       last_dir_next;
  logic             moving;

  assign moving = enable && ((direction == DIR_INC) || (direction == DIR_DEC));

  // The step for an update is chosen from the run length *including* that
  // update, so the fifth same-direction update is the first doubled one.
  always_comb begin
    run_next      = run_q;
    last_dir_next = last_dir_q;
    if (update_now) begin
      if (!moving) begin
        run_next      = '0;
        last_dir_next = DIR_HOLD;
      end else if (direction == last_dir_q) begin
        run_next      = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        last_dir_next = direction;
      end else begin
        run_next      = '0;
        last_dir_next = direction;
      end
    end

    if (run_next >= RAMP_HIGH_RUN) begin
      step_ext = STEP_X4;
    end else if (run_next >= RAMP_MID_RUN) begin
      step_ext = STEP_X2;
    end else begin
      step_ext = STEP_X1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      run_q      <= '0;
      last_dir_q <= DIR_HOLD;
    end else begin
      run_q      <= run_next;
      last_dir_q <= last_dir_next;
    end
  end
`else
  assign step_ext = STEP_X1;
`endif

  // ---------------------------------------------------------------------------
  // Position integration with saturation
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pos_next;
  logic [AW-1:0] pos_ext;
  logic [AW-1:0] sum_ext;

  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    pos_next = position;
    pos_ext  = {1'b0, position};
    sum_ext  = pos_ext + step_ext;
    if (update_now && enable) begin
      case (direction)
        DIR_INC: pos_next = (sum_ext > MAX_EXT) ? MAX_POS : sum_ext[PW-1:0];
        // Compare before subtracting so the unsigned result never wraps.
        DIR_DEC: pos_next = (pos_ext < MIN_EXT + step_ext) ? MIN_POS
                                                           : PW'(pos_ext - step_ext);
        default: pos_next = position;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Position, latched width, PWM and limit flags
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pulse_q;

  // pulse_q takes the new position on the frame's first cycle; that cycle's
  // pwm_out still compares against the old width, but both are >= 1 so the
  // pulse is high either way and the high time equals the new width.
  always_ff @(posedge CLK) begin
    if (RST) begin
      position <= CENTER_POS;
      pulse_q  <= CENTER_POS;
      pwm_out  <= 1'b0;
      at_min   <= 1'b0;
      at_max   <= 1'b0;
    end else begin
      position <= pos_next;
      if (frame_start) begin
        pulse_q <= position;
      end
      pwm_out <= (frame_cnt < pulse_q);
      at_min  <= (position == MIN_POS);
      at_max  <= (position == MAX_POS);
    end
  end

endmodule

// File: tb/tb_servo_axis_driver.sv
// -----------------------------------------------------------------------------
// tb_servo_axis_driver
// Self-checking bench for servo_axis_driver with small frame parameters.
// A frame-level reference model (expected position, width and flags derived
// from the cycle index since reset) is compared against the DUT every cycle,
// plus a table of per-frame direction vectors and hand-written sequences for
// glitching directions, enable freeze and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_servo_axis_driver;

  localparam int P    = 100;
  localparam int MINP = 10;
  localparam int MAXP = 50;
  localparam int CEN  = 30;
  localparam int STEP = 5;
  localparam int FPU  = 1;
  localparam int PW   = $clog2(P + 1);

  localparam logic [1:0] D_HOLD = 2'b00;
  localparam logic [1:0] D_DEC  = 2'b01;
  localparam logic [1:0] D_INC  = 2'b10;
  localparam logic [1:0] D_BAD  = 2'b11;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [1:0]    direction = D_HOLD;
  logic          enable = 1'b1;
  logic          pwm_out;
  logic [PW-1:0] position;
  logic          frame_tick;
  logic          at_min;
  logic          at_max;

  always #5 CLK = ~CLK;

  servo_axis_driver #(
    .PWM_PERIOD_CYC    (P),
    .MIN_PULSE_CYC     (MINP),
    .MAX_PULSE_CYC     (MAXP),
    .CENTER_PULSE_CYC  (CEN),
    .STEP_CYC          (STEP),
    .FRAMES_PER_UPDATE (FPU)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .direction  (direction),
    .enable     (enable),
    .pwm_out    (pwm_out),
    .position   (position),
    .frame_tick (frame_tick),
    .at_min     (at_min),
    .at_max     (at_max)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d (t=%0t)", phase, name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: n counts clock edges since reset release. Frame k spans
  // edges k*P .. k*P+P-1; the last edge of every FPU-th frame applies one
  // update with the direction present at that edge.
  // ---------------------------------------------------------------------------
  int n;
  int m_pos;
  int m_width;
  int m_run;
  int m_last;

  task automatic model_reset();
    n       = 0;
    m_pos   = CEN;
    m_width = CEN;
    m_run   = 0;
    m_last  = 0;
  endtask

  task automatic model_update(input logic [1:0] d, input logic en);
    int step_now;
    bit moving;
    step_now = STEP;
    moving   = en && (d == D_INC || d == D_DEC);
`ifdef SERVO_RAMP_EN
    if (!moving) begin
      m_run  = 0;
      m_last = 0;
    end else begin
      if (int'(d) == m_last) m_run = (m_run < 15) ? m_run + 1 : 15;
      else                   m_run = 0;
      m_last = int'(d);
    end
    if (m_run >= 8)      step_now = 4 * STEP;
    else if (m_run >= 4) step_now = 2 * STEP;
`endif
    if (moving) begin
      if (d == D_INC) m_pos = (m_pos + step_now > MAXP) ? MAXP : m_pos + step_now;
      else            m_pos = (m_pos - step_now < MINP) ? MINP : m_pos - step_now;
    end
  endtask

  // One clock: model the edge with the inputs set beforehand, then compare at
  // the following falling edge.
  task automatic tick();
    int prev_pos;
    bit exp_pwm;
    bit exp_tick;
    @(posedge CLK);
    prev_pos = m_pos;
    if (n % P == 0) m_width = m_pos;
    exp_pwm  = (n % P) < m_width;
    exp_tick = (n % P) == 0;
    if ((n % P == P - 1) && ((n / P) % FPU == FPU - 1)) model_update(direction, enable);
    @(negedge CLK);
    check("pwm_out",    pwm_out,    exp_pwm);
    check("frame_tick", frame_tick, exp_tick);
    check("position",   position,   m_pos);
    check("at_min",     at_min,     prev_pos == MINP);
    check("at_max",     at_max,     prev_pos == MAXP);
    n++;
  endtask

  // Reset is applied for two edges, outputs checked while it is held, then
  // released on a falling edge so the next rising edge starts frame 0.
  task automatic do_reset();
    RST       = 1'b1;
    direction = D_HOLD;
    enable    = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_pwm",   pwm_out,    0);
    check("rst_pos",   position,   CEN);
    check("rst_tick",  frame_tick, 0);
    check("rst_min",   at_min,     0);
    check("rst_max",   at_max,     0);
    RST = 1'b0;
    model_reset();
  endtask

  // Per-frame vectors: inputs held for one frame, expected position at its
  // end and expected limit flags one cycle later.
  typedef struct {
    logic [1:0] dir;
    logic       en;
    int         exp_pos;
    bit         exp_min;
    bit         exp_max;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int highs;
    int guard;

    // Hold at center, climb into MAX, walk down into MIN, step off, then
    // disabled and invalid codes must hold.
    for (int i = 0; i < 5; i++) vecs.push_back('{D_HOLD, 1'b1, 30, 1'b0, 1'b0});
    vecs.push_back('{D_INC,  1'b1, 35, 1'b0, 1'b0});
    vecs.push_back('{D_INC,  1'b1, 40, 1'b0, 1'b0});
    vecs.push_back('{D_INC,  1'b1, 45, 1'b0, 1'b0});
    vecs.push_back('{D_INC,  1'b1, 50, 1'b0, 1'b1});
    vecs.push_back('{D_INC,  1'b1, 50, 1'b0, 1'b1});
    vecs.push_back('{D_DEC,  1'b1, 45, 1'b0, 1'b0});
    vecs.push_back('{D_DEC,  1'b1, 40, 1'b0, 1'b0});
    vecs.push_back('{D_DEC,  1'b1, 35, 1'b0, 1'b0});
    vecs.push_back('{D_DEC,  1'b1, 30, 1'b0, 1'b0});
    vecs.push_back('{D_HOLD, 1'b1, 30, 1'b0, 1'b0});
    vecs.push_back('{D_DEC,  1'b1, 25, 1'b0, 1'b0});
    vecs.push_back('{D_DEC,  1'b1, 20, 1'b0, 1'b0});
    vecs.push_back('{D_DEC,  1'b1, 15, 1'b0, 1'b0});
    vecs.push_back('{D_DEC,  1'b1, 10, 1'b1, 1'b0});
    vecs.push_back('{D_DEC,  1'b1, 10, 1'b1, 1'b0});
    vecs.push_back('{D_INC,  1'b1, 15, 1'b0, 1'b0});
    vecs.push_back('{D_INC,  1'b0, 15, 1'b0, 1'b0});
    vecs.push_back('{D_BAD,  1'b1, 15, 1'b0, 1'b0});

    phase = "reset";
    do_reset();

    phase = "table";
    for (int i = 0; i < vecs.size(); i++) begin
      direction = vecs[i].dir;
      enable    = vecs[i].en;
      tick();
      if (i > 0) begin
        check("vec_at_min", at_min, vecs[i-1].exp_min);
        check("vec_at_max", at_max, vecs[i-1].exp_max);
      end
      repeat (P - 1) tick();
      check("vec_position", position, vecs[i].exp_pos);
    end
    tick();
    check("vec_at_min", at_min, vecs[vecs.size()-1].exp_min);
    check("vec_at_max", at_max, vecs[vecs.size()-1].exp_max);

    // Direction glitching between updates, hold on every update cycle.
    phase = "glitch";
    enable = 1'b1;
    repeat (2 * P) begin
      if (n % P == P - 1) direction = D_HOLD;
      else                direction = (((n % P) / 7) % 2 == 1) ? D_DEC : D_INC;
      tick();
    end
    check("glitch_position", position, 15);

    // Enable low freezes the position while PWM keeps its width.
    phase = "freeze";
    enable    = 1'b0;
    direction = D_INC;
    highs     = 0;
    repeat (2 * P) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    check("freeze_position", position, 15);
    check("freeze_highs", highs, 30);

    // Climb to 45, then reset mid-pulse.
    phase = "climb";
    enable = 1'b1;
    guard  = 0;
    while (m_pos != 45 && guard < 12 * P) begin
      tick();
      guard++;
    end
    check("climb_reached", position, 45);
    direction = D_HOLD;
    guard = 0;
    while (n % P != 20 && guard < 2 * P) begin
      tick();
      guard++;
    end
    check("pre_rst_pwm", pwm_out, 1);

    phase = "midrst";
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("midrst_pwm", pwm_out,  0);
    check("midrst_pos", position, CEN);
    check("midrst_max", at_max,   0);
    RST = 1'b0;
    model_reset();
    highs = 0;
    repeat (P) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
    check("midrst_highs", highs, CEN);

    // Random directions and enable against the model.
    phase = "random";
    repeat (40 * P) begin
      direction = 2'($urandom_range(0, 3));
      enable    = ($urandom_range(0, 9) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
